uart_txrx_cfg: RTL

Parametrised full-duplex UART transceiver. It supersedes the fixed 8-bit transmit/receive pair and adds the following:
- configurable data width, parity mode, stop bits and bit period;
- a valid/ready transmit handshake;
- a held receive register with explicit acknowledge;
- parity, framing and overrun error flags.

It sits between the core's memory-mapped UART register block and the board pins. The display decoding stays outside this block.

---
 rtl/uart_txrx_cfg.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_txrx_cfg.sv
// Parametrised full-duplex UART: valid/ready transmitter plus a mid-bit sampling receiver
// with a held receive word and sticky parity/framing/overrun flags.
module uart_txrx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 tx_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = 4;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] DATA_END = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_END = IW'(STOP_BITS - 1);
  localparam logic          PAR_EN   = (PARITY_EN != 0);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (^w) ^ PAR_ODD;
  endfunction

  state_e                 tx_state_q, tx_state_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
  logic [IW-1:0]          tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_q, tx_d;
  logic                   tx_ready_q, tx_ready_d;

  // Transmitter next-state; the line level is computed from the next state so tx is a flop output.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = parity_of(tx_data);
          tx_state_d = S_START;
          tx_cnt_d   = CW'(0);
          tx_idx_d   = IW'(0);
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = CW'(0);
          tx_idx_d   = IW'(0);
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = CW'(0);
          tx_shift_d = tx_shift_q >> 1;
          if (tx_idx_q == DATA_END) begin
            tx_idx_d   = IW'(0);
            tx_state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            tx_idx_d = tx_idx_q + IW'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (tx_cnt_q == BIT_END) begin
          tx_state_d = S_STOP;
          tx_cnt_d   = CW'(0);
          tx_idx_d   = IW'(0);
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = CW'(0);
          if (tx_idx_q == STOP_END) begin
            tx_idx_d   = IW'(0);
            tx_state_d = S_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + IW'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = CW'(0);
        tx_idx_d   = IW'(0);
      end
    endcase
    case (tx_state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = tx_shift_d[0];
      S_PARITY: tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
    tx_ready_d = (tx_state_d == S_IDLE);
  end

  // Transmitter state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= CW'(0);
      tx_idx_q   <= IW'(0);
      tx_shift_q <= DATA_BITS'(0);
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = ~tx_ready_q;

  state_e                 rx_state_q, rx_state_d;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [IW-1:0]          rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_par_bad_q, rx_par_bad_d;
  logic                   rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   rx_done_s;

  // Receiver next-state: start bit is re-checked at half a bit, later bits one bit period apart.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_done_s    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d   = S_START;
          rx_cnt_d     = CW'(0);
          rx_idx_d     = IW'(0);
          rx_par_bad_d = 1'b0;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = CW'(0);
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = CW'(0);
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == DATA_END) begin
            rx_idx_d   = IW'(0);
            rx_state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            rx_idx_d = rx_idx_q + IW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d     = CW'(0);
          rx_state_d   = S_STOP;
          rx_par_bad_d = rx_s2_q ^ parity_of(rx_shift_q);
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = CW'(0);
          rx_state_d = S_IDLE;
          rx_done_s  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin
        rx_state_d = S_IDLE;
        rx_cnt_d   = CW'(0);
        rx_idx_d   = IW'(0);
      end
    endcase
    rx_data_d    = rx_done_s ? rx_shift_q : rx_data_q;
    rx_valid_d   = rx_done_s ? 1'b1 : (rx_ack ? 1'b0 : rx_valid_q);
    frame_err_d  = (frame_err_q & ~err_clr) | (rx_done_s & ~rx_s2_q);
    parity_err_d = (parity_err_q & ~err_clr) | (rx_done_s & rx_par_bad_q);
    overrun_d    = (overrun_q & ~err_clr) | (rx_done_s & rx_valid_q & ~rx_ack);
  end

  // Receiver state, synchroniser and held result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= CW'(0);
      rx_idx_q     <= IW'(0);
      rx_shift_q   <= DATA_BITS'(0);
      rx_par_bad_q <= 1'b0;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_data_q    <= DATA_BITS'(0);
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_idx_q     <= rx_idx_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_bad_q <= rx_par_bad_d;
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
